// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction timer.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FOUL   = 3'd4
  } state_t;

  localparam int SAT_MS_DEFAULT = 9999;
  localparam int TIME_W         = 14;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus rising-edge detect.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the raw input through the synchroniser and remember the last synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures the player's reaction time from lights-out to button press, tracks the
// best time since reset and flags jump starts.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int SAT_MS      = SAT_MS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        lights,
  input  logic              tick_ms,
  input  logic              btn,
  output logic [TIME_W-1:0] time_ms,
  output logic              time_valid,
  output logic              jump_start,
  output logic [TIME_W-1:0] best_ms,
  output logic              busy
);

  localparam logic [TIME_W-1:0] SAT_V = TIME_W'(SAT_MS);

  state_t            state_r, state_s;
  logic [TIME_W-1:0] counter_r, counter_s;
  logic [TIME_W-1:0] time_r, time_s;
  logic [TIME_W-1:0] best_r, best_s;
  logic [7:0]        lights_q_r;
  logic              seen_full_r, seen_full_s;
  logic              valid_r, valid_s;
  logic              jump_r, jump_s;
  logic              busy_r, busy_s;
  logic              btn_rise_s;
  logic              lights_out_s;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn),
    .rise (btn_rise_s)
  );

  // lights_q only sees a real 0xFF after reset, so lights-out cannot fire spuriously.
  assign lights_out_s = (lights_q_r == 8'hFF) && (lights == 8'h00);

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      counter_r   <= '0;
      time_r      <= '0;
      best_r      <= SAT_V;
      lights_q_r  <= 8'h00;
      seen_full_r <= 1'b0;
      valid_r     <= 1'b0;
      jump_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_s;
      time_r      <= time_s;
      best_r      <= best_s;
      lights_q_r  <= lights;
      seen_full_r <= seen_full_s;
      valid_r     <= valid_s;
      jump_r      <= jump_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    counter_s   = counter_r;
    time_s      = time_r;
    best_s      = best_r;
    seen_full_s = seen_full_r;
    valid_s     = valid_r;
    jump_s      = jump_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (lights != 8'h00) begin
          state_s     = ST_ARMED;
          valid_s     = 1'b0;
          jump_s      = 1'b0;
          counter_s   = '0;
          seen_full_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_ARMED: begin
        if (lights == 8'hFF) begin
          seen_full_s = 1'b1;
        end else begin
          seen_full_s = seen_full_r;
        end
        // A press before lights-out wins over lights-out in the same cycle.
        if (btn_rise_s) begin
          state_s = ST_FOUL;
          jump_s  = 1'b1;
        end else if (lights_out_s && seen_full_r) begin
          state_s   = ST_TIMING;
          counter_s = '0;
        end else if (lights == 8'h00) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_TIMING: begin
        if (btn_rise_s) begin
          state_s = ST_DONE;
          time_s  = counter_r;
          valid_s = 1'b1;
          if (counter_r < best_r) begin
            best_s = counter_r;
          end else begin
            best_s = best_r;
          end
        end else if (counter_r == SAT_V) begin
          state_s = ST_DONE;
          time_s  = SAT_V;
          valid_s = 1'b1;
        end else if (tick_ms && (counter_r < SAT_V)) begin
          counter_s = counter_r + 14'd1;
        end else begin
          counter_s = counter_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_ARMED) || (state_s == ST_TIMING);
  end

  assign time_ms    = time_r;
  assign time_valid = valid_r;
  assign jump_start = jump_r;
  assign best_ms    = best_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed self-checking bench for f1_reaction_timer.
module tb_f1_reaction_timer;

  logic        clk;
  logic        rst;
  logic [7:0]  lights;
  logic        tick_ms;
  logic        btn;
  logic [13:0] time_ms;
  logic        time_valid;
  logic        jump_start;
  logic [13:0] best_ms;
  logic        busy;

  int tests;
  int fails;

  f1_reaction_timer dut (
    .clk        (clk),
    .rst        (rst),
    .lights     (lights),
    .tick_ms    (tick_ms),
    .btn        (btn),
    .time_ms    (time_ms),
    .time_valid (time_valid),
    .jump_start (jump_start),
    .best_ms    (best_ms),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full start sequence 0x01..0xFF then lights out; DUT enters TIMING on the next edge.
  task automatic lights_seq();
    logic [7:0] pat [8];
    pat = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lights = pat[i];
    end
    @(negedge clk);
    lights = 8'h00;
  endtask

  // Each tick is a one-cycle strobe followed by a quiet cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_ms = 1'b1;
      @(negedge clk);
      tick_ms = 1'b0;
    end
  endtask

  // Raise btn, wait past the synchroniser and the deciding edge, then release.
  task automatic press();
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    lights  = 8'h00;
    tick_ms = 1'b0;
    btn     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_time", time_ms, 0);
    check("rst_valid", time_valid, 0);
    check("rst_jump", jump_start, 0);
    check("rst_best", best_ms, 9999);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Run 1: 250 ms
    lights_seq();
    @(negedge clk);
    check("run1_busy", busy, 1);
    ticks(250);
    press();
    check("run1_time", time_ms, 250);
    check("run1_valid", time_valid, 1);
    check("run1_best", best_ms, 250);
    check("run1_jump", jump_start, 0);
    check("run1_busy_done", busy, 0);

    // Button in DONE is ignored
    press();
    @(negedge clk);
    check("done_btn_time", time_ms, 250);
    check("done_btn_valid", time_valid, 1);

    // Run 2: 180 ms improves best
    lights_seq();
    ticks(180);
    press();
    check("run2_time", time_ms, 180);
    check("run2_best", best_ms, 180);

    // Run 3: 300 ms keeps best
    lights_seq();
    ticks(300);
    press();
    check("run3_time", time_ms, 300);
    check("run3_best", best_ms, 180);

    // Jump start while lights = 0x0F
    @(negedge clk); lights = 8'h01;
    @(negedge clk); lights = 8'h03;
    @(negedge clk); lights = 8'h07;
    @(negedge clk); lights = 8'h0F;
    @(negedge clk);
    check("arm_valid_clr", time_valid, 0);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    check("foul_jump", jump_start, 1);
    check("foul_valid", time_valid, 0);
    check("foul_busy", busy, 0);
    btn    = 1'b0;
    lights = 8'h00;
    repeat (2) @(negedge clk);
    check("foul_hold_jump", jump_start, 1);
    check("foul_hold_time", time_ms, 300);
    check("foul_hold_best", best_ms, 180);
    lights = 8'h01;
    @(negedge clk);
    check("rearm_busy", busy, 1);
    check("rearm_jump", jump_start, 0);

    // Timeout: no press after lights out
    lights_seq();
    ticks(9998);
    @(negedge clk);
    check("pre_timeout_valid", time_valid, 0);
    check("pre_timeout_busy", busy, 1);
    ticks(1);
    @(negedge clk);
    check("timeout_time", time_ms, 9999);
    check("timeout_valid", time_valid, 1);
    check("timeout_best", best_ms, 180);
    ticks(1);
    check("timeout_hold", time_ms, 9999);

    // Press and tick coincide at counter 42
    lights_seq();
    ticks(42);
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick_ms = 1'b1;
    @(negedge clk);
    tick_ms = 1'b0;
    btn     = 1'b0;
    check("same_cycle_time", time_ms, 42);
    check("same_cycle_valid", time_valid, 1);
    check("same_cycle_best", best_ms, 42);

    // Aborted sequence returns to IDLE without touching the result
    @(negedge clk); lights = 8'h01;
    @(negedge clk); lights = 8'h03;
    @(negedge clk); lights = 8'h00;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_time", time_ms, 42);
    check("abort_best", best_ms, 42);

    // Reset mid-TIMING at counter 77
    lights_seq();
    ticks(77);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    lights = 8'hFF;
    rst    = 1'b1;
    #1;
    check("midrst_time", time_ms, 0);
    check("midrst_valid", time_valid, 0);
    check("midrst_jump", jump_start, 0);
    check("midrst_best", best_ms, 9999);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    lights = 8'h00;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", time_valid, 0);

    // A fresh run after reset still works
    lights_seq();
    ticks(5);
    press();
    check("post_rst_time", time_ms, 5);
    check("post_rst_best", best_ms, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
